// File: rtl/onewire_master.sv
// onewire_master: Avalon-MM controlled 1-Wire bus master.
// The CPU loads a byte into DATA and issues RESET / WRITE_BYTE / READ_BYTE through
// CTRL. All reset-pulse and time-slot timing is generated here from a 1 us tick.
// The pin is only ever driven low or released; an external pull-up provides the high level.
//
// Optional build macro: ONEWIRE_IRQ_EN adds the irq port and the IRQ_EN register at address 2.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a command, line released
// RST_LOW   | 480 us reset pulse, line driven low
// RST_WAIT  | line released, presence sampled at 70 us, leave at 480 us
// SLOT_LOW  | start of a bit slot, line low for 6 us (1/read) or 60 us (0)
// SLOT_HIGH | rest of the 70 us slot released; read bits sampled at 15 us
// DONE      | one cycle: clear busy, set done, publish received byte
module onewire_master #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    inout  wire         bidir_port
`ifdef ONEWIRE_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_LOW   = 3'd1,
        S_RST_WAIT  = 3'd2,
        S_SLOT_LOW  = 3'd3,
        S_SLOT_HIGH = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_RESET = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b11;

    localparam logic [9:0] PRESC_MAX    = 10'(CLK_DIV - 1);
    localparam logic [9:0] US_RST_END   = 10'd479;
    localparam logic [9:0] US_PRESENCE  = 10'd69;
    localparam logic [9:0] US_SHORT_END = 10'd5;
    localparam logic [9:0] US_LONG_END  = 10'd59;
    localparam logic [9:0] US_READ_SMP  = 10'd14;
    localparam logic [9:0] US_SLOT_END  = 10'd69;

    state_t      state, state_next;
    logic [9:0]  presc;
    logic [9:0]  us_cnt;
    logic        tick;
    logic        busy, done, presence;
    logic [7:0]  tx_byte, rx_byte, rx_shift;
    logic [1:0]  op;
    logic [2:0]  bit_cnt;
    logic [1:0]  line_sync;
    logic        synced_line;
    logic        drive_low;
    logic        irq_en;

    logic        bus_wr, ctrl_wr, data_wr, accept;
    logic        clr_us, sample_presence, sample_rx, bit_adv, finish;
    logic        cur_bit_one;
    logic [9:0]  low_end_us;

    logic        unused_wdata;
    assign unused_wdata = ^writedata[31:8];

    assign bus_wr  = chipselect && !write_n;
    assign ctrl_wr = bus_wr && (address == 3'd0) && !busy;
    assign data_wr = bus_wr && (address == 3'd1) && !busy;
    assign accept  = ctrl_wr && (writedata[1:0] != CMD_CLEAR);

    assign tick        = (presc == PRESC_MAX);
    assign synced_line = line_sync[1];
    assign bidir_port  = drive_low ? 1'b0 : 1'bz;

    assign cur_bit_one = (op == CMD_READ) || tx_byte[bit_cnt];
    assign low_end_us  = cur_bit_one ? US_SHORT_END : US_LONG_END;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // next-state decode plus one-cycle control strobes for the datapath
    always_comb begin
        state_next      = state;
        clr_us          = 1'b0;
        sample_presence = 1'b0;
        sample_rx       = 1'b0;
        bit_adv         = 1'b0;
        finish          = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    clr_us     = 1'b1;
                    state_next = (writedata[1:0] == CMD_RESET) ? S_RST_LOW : S_SLOT_LOW;
                end
            end
            S_RST_LOW: begin
                if (tick && us_cnt == US_RST_END) begin
                    clr_us     = 1'b1;
                    state_next = S_RST_WAIT;
                end
            end
            S_RST_WAIT: begin
                if (tick && us_cnt == US_PRESENCE) sample_presence = 1'b1;
                if (tick && us_cnt == US_RST_END)  state_next = S_DONE;
            end
            S_SLOT_LOW: begin
                // us_cnt keeps running into SLOT_HIGH so it measures from slot start
                if (tick && us_cnt == low_end_us) state_next = S_SLOT_HIGH;
            end
            S_SLOT_HIGH: begin
                if (tick && us_cnt == US_READ_SMP && op == CMD_READ) sample_rx = 1'b1;
                if (tick && us_cnt == US_SLOT_END) begin
                    bit_adv    = 1'b1;
                    clr_us     = 1'b1;
                    state_next = (bit_cnt == 3'd7) ? S_DONE : S_SLOT_LOW;
                end
            end
            S_DONE: begin
                finish     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // 1 us prescaler, restarted on command accept so the first phase is exact
    always_ff @(posedge clk) begin
        if (reset)              presc <= '0;
        else if (accept || tick) presc <= '0;
        else                    presc <= presc + 10'd1;
    end

    // microsecond counter within the current phase
    always_ff @(posedge clk) begin
        if (reset)       us_cnt <= '0;
        else if (clr_us) us_cnt <= '0;
        else if (tick)   us_cnt <= us_cnt + 10'd1;
    end

    // line driver is registered from next state so the pin never glitches
    always_ff @(posedge clk) begin
        if (reset) drive_low <= 1'b0;
        else       drive_low <= (state_next == S_RST_LOW) || (state_next == S_SLOT_LOW);
    end

    // two-flop synchroniser on the open-drain line (idle level is high)
    always_ff @(posedge clk) begin
        if (reset) line_sync <= 2'b11;
        else       line_sync <= {line_sync[0], bidir_port};
    end

    // command, status and bit-position bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            op      <= CMD_CLEAR;
            bit_cnt <= '0;
        end else begin
            if (ctrl_wr) done <= 1'b0;
            if (accept) begin
                busy    <= 1'b1;
                op      <= writedata[1:0];
                bit_cnt <= '0;
            end
            if (bit_adv) bit_cnt <= bit_cnt + 3'd1;
            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    // data bytes and presence; rx_byte only changes when a read completes
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_byte  <= '0;
            rx_byte  <= '0;
            rx_shift <= '0;
            presence <= 1'b0;
        end else begin
            if (data_wr)         tx_byte <= writedata[7:0];
            if (sample_presence) presence <= !synced_line;
            if (sample_rx)       rx_shift[bit_cnt] <= synced_line;
            if (finish && op == CMD_READ) rx_byte <= rx_shift;
        end
    end

`ifdef ONEWIRE_IRQ_EN
    // interrupt enable, writable regardless of busy
    always_ff @(posedge clk) begin
        if (reset)                            irq_en <= 1'b0;
        else if (bus_wr && address == 3'd2)   irq_en <= writedata[0];
    end

    assign irq = done && irq_en;
`else
    assign irq_en = 1'b0;
`endif

    // registered read mux, one cycle latency
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                3'd0:    readdata <= {29'b0, done, presence, busy};
                3'd1:    readdata <= {24'b0, rx_byte};
                3'd2:    readdata <= {31'b0, irq_en};
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_master.sv
// tb_onewire_master: randomized bench for onewire_master with a behavioural
// 1-Wire slave and a pulse monitor. Expected timings and bytes come from the
// protocol rules (slot widths in us times CLK_DIV), not from the design.
module tb_onewire_master;

    localparam int CLK_DIV = 2;
    localparam int US      = CLK_DIV * 10;   // time units per microsecond (clk period 10)

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    wire         bus;
    logic        irq;

    logic        slave_low = 1'b0;
    int          slave_mode = 0;   // 0 silent, 1 presence responder, 2 read responder
    int          pres_start, pres_end;
    logic [7:0]  read_mask;
    int          slave_slot;

    int          tests = 0;
    int          fails = 0;
    int          busy_drop;
    int          cyc = 0;
    int          run = 0;
    int          run_start = 0;
    int          pw[$];
    int          ps[$];

    logic [7:0]  m_tx, m_rx;
    logic        m_pres;

    assign bus = slave_low ? 1'b0 : 1'bz;
    pullup (bus);

    always #5 clk = ~clk;

    onewire_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .bidir_port (bus)
`ifdef ONEWIRE_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

`ifndef ONEWIRE_IRQ_EN
    assign irq = 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // record every low pulse driven by the master (slave pulls are excluded)
    always @(negedge clk) begin
        if (!bus && !slave_low) begin
            if (run == 0) run_start <= cyc;
            run <= run + 1;
        end else if (run > 0) begin
            pw.push_back(run);
            ps.push_back(run_start);
            run <= 0;
        end
    end

    // behavioural slave: answers a reset with a presence pulse, or holds
    // selected read slots low shortly after the master releases the line
    always begin
        @(negedge bus);
        if (!slave_low) begin
            if (slave_mode == 1) begin
                @(posedge bus);
                #(pres_start * US);
                slave_low = 1'b1;
                #((pres_end - pres_start) * US);
                slave_low = 1'b0;
            end else if (slave_mode == 2) begin
                if (slave_slot < 8 && read_mask[slave_slot[2:0]]) begin
                    #(8 * US);
                    slave_low = 1'b1;
                    #(22 * US);
                    slave_low = 1'b0;
                end
                slave_slot = slave_slot + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        int n;
        seen      = 1'b0;
        n         = 0;
        busy_drop = 0;
        address   = 3'd0;
        while (!seen && n < 5000) begin
            @(negedge clk);
            if (readdata[2]) seen = 1'b1;
            else if (!readdata[0]) busy_drop++;
            n++;
        end
        check({tag, "_finish"}, 32'(seen), 32'd1);
    endtask

    task automatic do_reset(input int mode, input int s, input int e, input bit poke);
        slave_mode = mode;
        pres_start = s;
        pres_end   = e;
        pw.delete();
        ps.delete();
        wr(3'd0, 32'd1);
        if (poke) begin
            repeat (200) @(negedge clk);
            wr(3'd0, 32'd2);
            wr(3'd1, {24'b0, ~m_tx});
        end
        wait_done("rst");
        m_pres = (mode == 1) && (s < 70) && (e > 70);
        check("rst_status", {29'b0, readdata[2:0]}, {29'b0, 1'b1, m_pres, 1'b0});
        check("rst_pulses", pw.size(), 1);
        check("rst_width", (pw.size() > 0) ? pw[0] : 0, 480 * CLK_DIV);
        check("rst_busy", busy_drop, 0);
        slave_mode = 0;
    endtask

    task automatic check_slots(input string tag, input logic [7:0] pattern);
        check({tag, "_pulses"}, pw.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_w%0d", tag, i), (i < pw.size()) ? pw[i] : 0,
                  pattern[i] ? 6 * CLK_DIV : 60 * CLK_DIV);
            if (i > 0)
                check($sformatf("%s_p%0d", tag, i),
                      (i < ps.size()) ? ps[i] - ps[i-1] : 0, 70 * CLK_DIV);
        end
    endtask

    task automatic do_write_byte(input bit load, input logic [7:0] b);
        pw.delete();
        ps.delete();
        if (load) begin
            wr(3'd1, {24'b0, b});
            m_tx = b;
        end
        wr(3'd0, 32'd2);
        wait_done("wb");
        check("wb_status", {29'b0, readdata[2:0]}, {29'b0, 1'b1, m_pres, 1'b0});
        check_slots("wb", m_tx);
    endtask

    task automatic do_read(input logic [7:0] mask);
        logic [31:0] d;
        slave_mode = 2;
        slave_slot = 0;
        read_mask  = mask;
        pw.delete();
        ps.delete();
        wr(3'd0, 32'd3);
        wait_done("rb");
        m_rx = ~mask;
        check_slots("rb", 8'hFF);
        rd(3'd1, d);
        check("rb_data", d, {24'b0, m_rx});
        slave_mode = 0;
    endtask

    initial begin
        logic [31:0] d;
        int s;
        reset      = 1'b1;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        m_tx = 8'h00; m_rx = 8'h00; m_pres = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;

        check("reset_readdata", readdata, 32'd0);
        check("reset_line", 32'(bus), 32'd1);
        rd(3'd0, d); check("reset_status", d, 32'd0);
        rd(3'd1, d); check("reset_rx", d, 32'd0);
        rd(3'd2, d); check("reset_irqen", d, 32'd0);
        check("reset_no_pulses", pw.size(), 0);

        do_reset(1, 20, 200, 1'b0);
        do_reset(0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                s = $urandom_range(15, 60);
                do_reset(1, s, $urandom_range(100, 240), 1'b0);
            end else begin
                s = $urandom_range(75, 150);
                do_reset(1, s, s + 60, 1'b0);
            end
        end

        do_write_byte(1'b1, 8'hA5);
        for (int i = 0; i < 4; i++) do_write_byte(1'b1, 8'($urandom));
        rd(3'd1, d); check("rx_hold_after_write", d, {24'b0, m_rx});

        do_read(8'h42);
        for (int i = 0; i < 3; i++) do_read(8'($urandom));
        do_write_byte(1'b1, 8'($urandom));
        rd(3'd1, d); check("rx_hold_after_wb", d, {24'b0, m_rx});

        wr(3'd0, 32'd0);
        rd(3'd0, d); check("clear_done", d, {29'b0, 1'b0, m_pres, 1'b0});

        // commands and data writes while busy are ignored
        do_reset(0, 0, 0, 1'b1);
        do_write_byte(1'b0, 8'h00);

        // DATA write landing in the DONE cycle is ignored
        m_tx = 8'($urandom);
        pw.delete(); ps.delete();
        wr(3'd1, {24'b0, m_tx});
        wr(3'd0, 32'd2);
        repeat (8 * 70 * CLK_DIV) @(negedge clk);
        wr(3'd1, {24'b0, ~m_tx});
        wait_done("done_cycle");
        check_slots("done_cycle", m_tx);
        do_write_byte(1'b0, 8'h00);

        // synchronous reset 30 us into a write-0 slot
        wr(3'd1, 32'hF0);
        wr(3'd0, 32'd2);
        repeat (30 * CLK_DIV - 1) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_line", 32'(bus), 32'd1);
        check("midrst_readdata", readdata, 32'd0);
        reset = 1'b0;
        m_tx = 8'h00; m_rx = 8'h00; m_pres = 1'b0;
        rd(3'd0, d); check("midrst_status", d, 32'd0);
        rd(3'd1, d); check("midrst_rx", d, 32'd0);
        do_reset(0, 0, 0, 1'b0);
        do_write_byte(1'b0, 8'h00);

`ifdef ONEWIRE_IRQ_EN
        wr(3'd2, 32'd1);
        rd(3'd2, d); check("irqen_rd", d, 32'd1);
        do_read(8'($urandom));
        check("irq_set", 32'(irq), 32'd1);
        wr(3'd0, 32'd0);
        check("irq_clear", 32'(irq), 32'd0);
`else
        wr(3'd2, 32'd1);
        rd(3'd2, d); check("addr2_ignored", d, 32'd0);
        check("irq_absent", 32'(irq), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
